fetch_eip_ctrl: RTL and testbench

//  Next-EIP selection/control stage feeding the 2-bit-load EIP register of the fetch unit.

---
 rtl/fetch_eip_ctrl.sv | 126 ++++++++++++
 tb/tb_fetch_eip_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_eip_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_eip_ctrl
//   Next-EIP selection/control for the fetch unit's EIP register, which has a
//   2-bit load select. This block drives that select plus the three candidate
//   load values. It also buffers a branch redirect that arrives while fetch is
//   stalled, and produces the one-cycle boot load of RESET_VEC after reset.
//
// Ports
//   clk           clock
//   rst_n         asynchronous active-low reset
//   stall_i       fetch stalled; EIP must hold (exceptions still win)
//   eip_cur_i     current EIP register value
//   fetch_len_i   bytes consumed this cycle (0..16, 0 = no advance)
//   redir_vld_i   branch redirect request
//   redir_tgt_i   redirect target
//   exc_vld_i     exception / interrupt flush request
//   exc_vec_i     exception handler address
//   ld_o          EIP select: 00 hold, 01 data1, 10 data2, 11 data3
//   data1_o       sequential next EIP (eip_cur_i + fetch_len_i, wrapping)
//   data2_o       redirect target (live or buffered)
//   data3_o       exception vector, or RESET_VEC while booting
//   redir_pend_o  a buffered redirect is waiting
// ---------------------------------------------------------------------------
module fetch_eip_ctrl #(
  parameter int             N         = 32,
  parameter logic [N-1:0]   RESET_VEC = 32'hFFFF_FFF0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall_i,
  input  logic [N-1:0] eip_cur_i,
  input  logic [4:0]   fetch_len_i,
  input  logic         redir_vld_i,
  input  logic [N-1:0] redir_tgt_i,
  input  logic         exc_vld_i,
  input  logic [N-1:0] exc_vec_i,
  output logic [1:0]   ld_o,
  output logic [N-1:0] data1_o,
  output logic [N-1:0] data2_o,
  output logic [N-1:0] data3_o,
  output logic         redir_pend_o
);

  localparam logic [1:0] LD_HOLD = 2'b00;
  localparam logic [1:0] LD_SEQ  = 2'b01;
  localparam logic [1:0] LD_REDIR = 2'b10;
  localparam logic [1:0] LD_EXC  = 2'b11;

  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_RUN  = 2'b01,
    S_PEND = 2'b10
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] buf_q, buf_d;
  logic         pend_q, pend_d;

  // Sequential next EIP: zero-extend the byte count, carry out is discarded.
  assign data1_o      = eip_cur_i + N'(fetch_len_i);
  assign redir_pend_o = pend_q;

  always_comb begin
    ld_o    = LD_HOLD;
    data2_o = redir_tgt_i;
    data3_o = exc_vec_i;
    state_d = state_q;
    buf_d   = buf_q;
    pend_d  = pend_q;

    case (state_q)
      S_RUN: begin
        if (exc_vld_i) begin
          ld_o = LD_EXC;
        end else if (redir_vld_i && !stall_i) begin
          ld_o = LD_REDIR;
        end else if (redir_vld_i) begin
          // Stalled redirect: remember it until fetch can move.
          buf_d   = redir_tgt_i;
          pend_d  = 1'b1;
          state_d = S_PEND;
        end else if (!stall_i && (fetch_len_i != 5'd0)) begin
          ld_o = LD_SEQ;
        end
      end

      S_PEND: begin
        // A live redirect in this cycle supersedes the buffered one.
        data2_o = redir_vld_i ? redir_tgt_i : buf_q;
        if (exc_vld_i) begin
          ld_o    = LD_EXC;
          buf_d   = '0;
          pend_d  = 1'b0;
          state_d = S_RUN;
        end else if (!stall_i) begin
          ld_o    = LD_REDIR;
          pend_d  = 1'b0;
          state_d = S_RUN;
        end else if (redir_vld_i) begin
          buf_d = redir_tgt_i;
        end
      end

      default: begin
        // BOOT (and the unused encoding): one unconditional reset-vector load.
        ld_o    = LD_EXC;
        data3_o = RESET_VEC;
        pend_d  = 1'b0;
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      buf_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_fetch_eip_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_eip_ctrl
//   Directed and random stimulus for fetch_eip_ctrl, checked against a
//   behavioural model: a "boot pending" flag plus a queue holding at most one
//   waiting redirect target (newest redirect replaces the queue content).
// ---------------------------------------------------------------------------
module tb_fetch_eip_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic [31:0] eip_cur_i;
  logic [4:0]  fetch_len_i;
  logic        redir_vld_i;
  logic [31:0] redir_tgt_i;
  logic        exc_vld_i;
  logic [31:0] exc_vec_i;
  logic [1:0]  ld_o;
  logic [31:0] data1_o, data2_o, data3_o;
  logic        redir_pend_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit          m_boot;
  logic [31:0] m_q[$];

  always #5 clk = ~clk;

  fetch_eip_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .eip_cur_i    (eip_cur_i),
    .fetch_len_i  (fetch_len_i),
    .redir_vld_i  (redir_vld_i),
    .redir_tgt_i  (redir_tgt_i),
    .exc_vld_i    (exc_vld_i),
    .exc_vec_i    (exc_vec_i),
    .ld_o         (ld_o),
    .data1_o      (data1_o),
    .data2_o      (data2_o),
    .data3_o      (data3_o),
    .redir_pend_o (redir_pend_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs 1ns later,
  // then let the posedge update the DUT and the model.
  task automatic step(input string tag, input logic st, input logic [4:0] len,
                      input logic rv, input logic [31:0] rt,
                      input logic ex, input logic [31:0] ev,
                      input logic [31:0] eip);
    logic [1:0]  e_ld;
    logic [31:0] e_d2, e_d3, e_d1, tgt;
    logic [32:0] sum;
    bit          n_boot;
    logic [31:0] n_q[$];

    stall_i = st; fetch_len_i = len; redir_vld_i = rv; redir_tgt_i = rt;
    exc_vld_i = ex; exc_vec_i = ev; eip_cur_i = eip;
    #1;

    sum    = {1'b0, eip} + {28'd0, len};
    e_d1   = sum[31:0];
    e_d2   = 32'h0;
    e_d3   = ev;
    n_boot = 1'b0;
    n_q    = m_q;
    if (m_boot) begin
      e_ld = 2'd3;
      e_d3 = 32'hFFFF_FFF0;
    end else if (ex) begin
      e_ld = 2'd3;
      n_q.delete();
    end else if (rv || m_q.size() != 0) begin
      tgt = rv ? rt : m_q[0];
      if (st) begin
        e_ld = 2'd0;
        n_q.delete();
        n_q.push_back(tgt);
      end else begin
        e_ld = 2'd2;
        e_d2 = tgt;
        n_q.delete();
      end
    end else begin
      e_ld = (!st && len != 5'd0) ? 2'd1 : 2'd0;
    end

    chk({tag, ".ld"}, {30'd0, ld_o}, {30'd0, e_ld});
    chk({tag, ".data1"}, data1_o, e_d1);
    chk({tag, ".pend"}, {31'd0, redir_pend_o}, {31'd0, (m_q.size() != 0)});
    if (e_ld == 2'd3) chk({tag, ".data3"}, data3_o, e_d3);
    if (e_ld == 2'd2) chk({tag, ".data2"}, data2_o, e_d2);
    $display("%s: stall=%b len=%0d rv=%b ex=%b -> ld=%b d1=%h d2=%h d3=%h pend=%b",
             tag, st, len, rv, ex, ld_o, data1_o, data2_o, data3_o, redir_pend_o);

    @(posedge clk);
    m_boot = n_boot;
    m_q    = n_q;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b1; eip_cur_i = '0; fetch_len_i = '0;
    redir_vld_i = 1'b0; redir_tgt_i = '0; exc_vld_i = 1'b0; exc_vec_i = '0;
    m_boot = 1'b1;
    m_q.delete();
    repeat (2) @(negedge clk);
    #1;
    chk("rst.ld", {30'd0, ld_o}, 32'd3);
    chk("rst.data3", data3_o, 32'hFFFF_FFF0);
    chk("rst.pend", {31'd0, redir_pend_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Boot load then hold under stall
    step("boot0", 1, 0, 0, 32'h0, 0, 32'h0, 32'h0);
    step("boot1", 1, 0, 0, 32'h0, 0, 32'h0, 32'h0);
    // Sequential advance and wrap
    step("seq16", 0, 16, 0, 32'h0, 0, 32'h0, 32'h0000_1000);
    step("wrap", 0, 8, 0, 32'h0, 0, 32'h0, 32'hFFFF_FFFC);
    step("len0", 0, 0, 0, 32'h0, 0, 32'h0, 32'h0000_2222);
    // Stalled redirect, three stall cycles, stall drop
    step("rdst0", 1, 4, 1, 32'h0000_2000, 0, 32'h0, 32'h100);
    step("rdst1", 1, 4, 0, 32'h0, 0, 32'h0, 32'h100);
    step("rdst2", 1, 4, 0, 32'h0, 0, 32'h0, 32'h100);
    step("rdst3", 1, 4, 0, 32'h0, 0, 32'h0, 32'h100);
    step("rdrop", 0, 4, 0, 32'h0, 0, 32'h0, 32'h100);
    step("rdone", 0, 4, 0, 32'h0, 0, 32'h0, 32'h100);
    // Second redirect while pending overrides
    step("ov0", 1, 0, 1, 32'h0000_2000, 0, 32'h0, 32'h200);
    step("ov1", 1, 0, 1, 32'h0000_3000, 0, 32'h0, 32'h200);
    step("ov2", 0, 0, 0, 32'h0, 0, 32'h0, 32'h200);
    // Pending redirect with live redirect on the release cycle
    step("lv0", 1, 0, 1, 32'h0000_4000, 0, 32'h0, 32'h200);
    step("lv1", 0, 0, 1, 32'h0000_5000, 0, 32'h0, 32'h200);
    // Exception while pending drops the buffer
    step("ex0", 1, 0, 1, 32'h0000_6000, 0, 32'h0, 32'h300);
    step("ex1", 1, 0, 0, 32'h0, 1, 32'h0000_0080, 32'h300);
    step("ex2", 1, 0, 0, 32'h0, 0, 32'h0, 32'h300);
    step("ex3", 0, 2, 0, 32'h0, 0, 32'h0, 32'h300);
    // Exception beats redirect in RUN
    step("exrd", 0, 2, 1, 32'h0000_7000, 1, 32'h0000_0100, 32'h300);
    // Unstalled redirect in RUN
    step("rdrun", 0, 2, 1, 32'h0000_8000, 0, 32'h0, 32'h300);

    // Reset asserted mid-PEND
    step("mp0", 1, 0, 1, 32'h0000_9000, 0, 32'h0, 32'h400);
    rst_n = 1'b0;
    #1;
    chk("mprst.pend", {31'd0, redir_pend_o}, 32'd0);
    chk("mprst.ld", {30'd0, ld_o}, 32'd3);
    chk("mprst.data3", data3_o, 32'hFFFF_FFF0);
    m_q.delete();
    m_boot = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("mpboot", 0, 4, 1, 32'h0000_A000, 1, 32'h0000_0200, 32'h400);
    step("mprun", 0, 4, 0, 32'h0, 0, 32'h0, 32'h400);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($sformatf("rnd%0d", i),
           ($urandom_range(99, 0) < 50),
           5'($urandom_range(16, 0)),
           ($urandom_range(99, 0) < 25),
           $urandom(),
           ($urandom_range(99, 0) < 8),
           $urandom(),
           $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
